// File: rtl/score_pkg.sv
// Shared BCD constants and types for the score tracker.
package score_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam logic DOT_OFF = 1'b1;
  localparam logic DOT_ON  = 1'b0;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  // Digit-index width, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bcd_score_tracker_if.sv
// Control and display signals of the BCD score tracker.
interface bcd_score_tracker_if
  import score_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4
) ();

  localparam int unsigned SW = idx_width(NUM_DIGITS);

  logic             TARGET_REACHED;
  logic [BCD_W-1:0] INC_VAL;
  logic             SCORE_CLEAR;
  logic             SHOW_HIGH;
  logic [SW-1:0]    STROBE_COUNT;
  logic [4:0]       SCORE_COUNT;
  logic             NEW_HIGH;
  logic             OVERFLOW;

  modport master (
    output TARGET_REACHED, INC_VAL, SCORE_CLEAR, SHOW_HIGH,
    input  STROBE_COUNT, SCORE_COUNT, NEW_HIGH, OVERFLOW
  );

  modport slave (
    input  TARGET_REACHED, INC_VAL, SCORE_CLEAR, SHOW_HIGH,
    output STROBE_COUNT, SCORE_COUNT, NEW_HIGH, OVERFLOW
  );

endinterface

// File: rtl/bcd_digit_adder.sv
// One decimal digit of the ripple-carry BCD adder.
module bcd_digit_adder
  import score_pkg::*;
(
  input  bcd_digit_t digit_i,
  input  bcd_digit_t addend_i,
  input  logic       carry_i,
  output bcd_digit_t sum_o,
  output logic       carry_o
);

  logic [BCD_W:0] raw;
  logic [BCD_W:0] adj;

  always_comb begin
    raw     = {1'b0, digit_i} + {1'b0, addend_i} + {{BCD_W{1'b0}}, carry_i};
    adj     = raw - (BCD_W + 1)'(10);
    sum_o   = raw[BCD_W-1:0];
    carry_o = 1'b0;
    if (raw > {1'b0, BCD_MAX}) begin
      sum_o   = adj[BCD_W-1:0];
      carry_o = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_score_tracker.sv
// BCD score counter with high-score memory and a multiplexed digit strobe.
module bcd_score_tracker
  import score_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned STROBE_DIV = 100000,
  parameter int unsigned SATURATE   = 1
) (
  input logic                CLK,
  input logic                RESET,
  bcd_score_tracker_if.slave bus_io
);

  localparam int unsigned SW = idx_width(NUM_DIGITS);
  localparam int unsigned PW = $clog2(STROBE_DIV);

  typedef bcd_digit_t [NUM_DIGITS-1:0] score_t;

  score_t              score_q, score_d, high_q, high_d, sum, addend;
  logic [NUM_DIGITS:0] carry;
  logic                new_high_q, new_high_d, overflow_q, overflow_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [SW-1:0]       strobe_q, strobe_d;
  logic                tick;
  bcd_digit_t          inc_eff, sel;
  logic                dot;

  always_comb begin
    inc_eff = bus_io.INC_VAL;
    if (bus_io.INC_VAL == '0 || bus_io.INC_VAL > BCD_MAX) inc_eff = bcd_digit_t'(1);
    addend    = '0;
    addend[0] = inc_eff;
  end

  assign carry[0] = 1'b0;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adder
    bcd_digit_adder u_adder (
      .digit_i  (score_q[g]),
      .addend_i (addend[g]),
      .carry_i  (carry[g]),
      .sum_o    (sum[g]),
      .carry_o  (carry[g+1])
    );
  end

  // Packed BCD compares correctly as a plain binary vector.
  always_comb begin
    score_d    = score_q;
    high_d     = high_q;
    new_high_d = new_high_q;
    overflow_d = overflow_q;
    if (bus_io.SCORE_CLEAR) begin
      if (score_q > high_q) high_d = score_q;
      score_d    = '0;
      new_high_d = 1'b0;
      overflow_d = 1'b0;
    end else begin
      if (bus_io.TARGET_REACHED) begin
        score_d = sum;
        if (carry[NUM_DIGITS]) begin
          overflow_d = 1'b1;
          if (SATURATE != 0) score_d = {NUM_DIGITS{BCD_MAX}};
        end
      end
      if (score_d > high_q) new_high_d = 1'b1;
    end
  end

  always_comb begin
    tick     = (presc_q == PW'(STROBE_DIV - 1));
    presc_d  = tick ? '0 : presc_q + PW'(1);
    strobe_d = strobe_q;
    if (tick) strobe_d = (strobe_q == SW'(NUM_DIGITS - 1)) ? '0 : strobe_q + SW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      score_q    <= '0;
      high_q     <= '0;
      new_high_q <= 1'b0;
      overflow_q <= 1'b0;
      presc_q    <= '0;
      strobe_q   <= '0;
    end else begin
      score_q    <= score_d;
      high_q     <= high_d;
      new_high_q <= new_high_d;
      overflow_q <= overflow_d;
      presc_q    <= presc_d;
      strobe_q   <= strobe_d;
    end
  end

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (strobe_q == SW'(i)) sel = bus_io.SHOW_HIGH ? high_q[i] : score_q[i];
    end
    dot = (bus_io.SHOW_HIGH && strobe_q == SW'(NUM_DIGITS - 1)) ? DOT_ON : DOT_OFF;
  end

  assign bus_io.STROBE_COUNT = strobe_q;
  assign bus_io.SCORE_COUNT  = {dot, sel};
  assign bus_io.NEW_HIGH     = new_high_q;
  assign bus_io.OVERFLOW     = overflow_q;

endmodule

// File: tb/tb_bcd_score_tracker.sv
// Scoreboard bench: three trackers (4-digit saturating, 4-digit wrapping, 3-digit) share stimulus.
module tb_bcd_score_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tr = 1'b0;
  logic       clr = 1'b0;
  logic       show = 1'b0;
  logic [3:0] inc = 4'd1;

  always #5 clk = ~clk;

  bcd_score_tracker_if #(.NUM_DIGITS(4)) if_a ();
  bcd_score_tracker_if #(.NUM_DIGITS(4)) if_b ();
  bcd_score_tracker_if #(.NUM_DIGITS(3)) if_c ();

  assign if_a.TARGET_REACHED = tr;
  assign if_a.INC_VAL        = inc;
  assign if_a.SCORE_CLEAR    = clr;
  assign if_a.SHOW_HIGH      = show;
  assign if_b.TARGET_REACHED = tr;
  assign if_b.INC_VAL        = inc;
  assign if_b.SCORE_CLEAR    = clr;
  assign if_b.SHOW_HIGH      = show;
  assign if_c.TARGET_REACHED = tr;
  assign if_c.INC_VAL        = inc;
  assign if_c.SCORE_CLEAR    = clr;
  assign if_c.SHOW_HIGH      = show;

  bcd_score_tracker #(.NUM_DIGITS(4), .STROBE_DIV(4), .SATURATE(1)) u_dut_a (
    .CLK(clk), .RESET(rst), .bus_io(if_a.slave)
  );
  bcd_score_tracker #(.NUM_DIGITS(4), .STROBE_DIV(4), .SATURATE(0)) u_dut_b (
    .CLK(clk), .RESET(rst), .bus_io(if_b.slave)
  );
  bcd_score_tracker #(.NUM_DIGITS(3), .STROBE_DIV(4), .SATURATE(1)) u_dut_c (
    .CLK(clk), .RESET(rst), .bus_io(if_c.slave)
  );

  typedef struct packed {
    int unsigned s;
    int unsigned h;
    logic        nh;
    logic        ov;
  } exp_t;

  exp_t        sb_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int unsigned ms[3], mh[3];
  bit          mnh[3], mov[3];
  int unsigned dig[3][4];
  bit          got[3][4];
  int unsigned disp[3];

  function automatic int nd(input int d);
    return (d == 2) ? 3 : 4;
  endfunction

  function automatic bit is_sat(input int d);
    return d != 1;
  endfunction

  function automatic int strobe_of(input int d);
    case (d)
      0:       return int'(if_a.STROBE_COUNT);
      1:       return int'(if_b.STROBE_COUNT);
      default: return int'(if_c.STROBE_COUNT);
    endcase
  endfunction

  function automatic logic [4:0] sc_of(input int d);
    case (d)
      0:       return if_a.SCORE_COUNT;
      1:       return if_b.SCORE_COUNT;
      default: return if_c.SCORE_COUNT;
    endcase
  endfunction

  function automatic logic [1:0] flags_of(input int d);
    case (d)
      0:       return {if_a.NEW_HIGH, if_a.OVERFLOW};
      1:       return {if_b.NEW_HIGH, if_b.OVERFLOW};
      default: return {if_c.NEW_HIGH, if_c.OVERFLOW};
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      ms[d] = 0; mh[d] = 0; mnh[d] = 1'b0; mov[d] = 1'b0;
    end
  endtask

  task automatic model_inc(input logic [3:0] v);
    int unsigned ve, lim;
    ve = (v == 4'd0 || v > 4'd9) ? 1 : int'(v);
    for (int d = 0; d < 3; d++) begin
      lim = (nd(d) == 3) ? 1000 : 10000;
      ms[d] = ms[d] + ve;
      if (ms[d] >= lim) begin
        mov[d] = 1'b1;
        ms[d]  = is_sat(d) ? lim - 1 : ms[d] - lim;
      end
      if (ms[d] > mh[d]) mnh[d] = 1'b1;
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 3; d++) begin
      if (ms[d] > mh[d]) mh[d] = ms[d];
      ms[d] = 0; mnh[d] = 1'b0; mov[d] = 1'b0;
    end
  endtask

  task automatic push_expect();
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      e.s = ms[d]; e.h = mh[d]; e.nh = mnh[d]; e.ov = mov[d];
      sb_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; tr = 1'b0; clr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic do_inc(input logic [3:0] v);
    tr = 1'b1; inc = v;
    @(posedge clk); #1;
    tr = 1'b0;
    model_inc(v);
  endtask

  task automatic do_clear(input logic with_inc);
    clr = 1'b1; tr = with_inc; inc = 4'd5;
    @(posedge clk); #1;
    clr = 1'b0; tr = 1'b0;
    model_clear();
  endtask

  task automatic capture(input int d, input int idx, input logic [4:0] sc);
    logic exp_dot;
    exp_dot = (show && idx == nd(d) - 1) ? 1'b0 : 1'b1;
    vectors++;
    if (sc[4] !== exp_dot) begin
      miscompares++;
      $display("FAIL dot dut%0d idx%0d got %b want %b", d, idx, sc[4], exp_dot);
    end
    vectors++;
    if (idx >= nd(d) || sc[3:0] > 4'd9 || $isunknown(sc)) begin
      miscompares++;
      $display("FAIL digit_range dut%0d got idx %0d digit %0d want idx<%0d digit<=9",
               d, idx, sc[3:0], nd(d));
    end else begin
      dig[d][idx] = int'(sc[3:0]);
      got[d][idx] = 1'b1;
    end
  endtask

  // Walks the strobe long enough to see every digit of every DUT.
  task automatic read_display(input logic hi);
    show = hi;
    for (int d = 0; d < 3; d++) for (int i = 0; i < 4; i++) got[d][i] = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk); #2;
      for (int d = 0; d < 3; d++) capture(d, strobe_of(d), sc_of(d));
    end
    for (int d = 0; d < 3; d++) begin
      disp[d] = 0;
      for (int i = nd(d) - 1; i >= 0; i--) begin
        vectors++;
        if (!got[d][i]) begin
          miscompares++;
          $display("FAIL strobe_coverage dut%0d digit %0d never shown within 20 cycles", d, i);
        end
        disp[d] = disp[d] * 10 + dig[d][i];
      end
    end
    show = 1'b0;
  endtask

  task automatic check_sb(input string tag);
    exp_t       e[3];
    logic [1:0] fl[3];
    vectors++;
    if (sb_q.size() < 3) begin
      miscompares++;
      $display("FAIL %s scoreboard empty got %0d entries want 3", tag, sb_q.size());
      return;
    end
    for (int d = 0; d < 3; d++) begin
      e[d]  = sb_q.pop_front();
      fl[d] = flags_of(d);
      vectors++;
      if (fl[d] !== {e[d].nh, e[d].ov}) begin
        miscompares++;
        $display("FAIL %s dut%0d new_high/overflow got %b want %b", tag, d, fl[d],
                 {e[d].nh, e[d].ov});
      end
    end
    read_display(1'b0);
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (disp[d] != e[d].s) begin
        miscompares++;
        $display("FAIL %s dut%0d score got %0d want %0d", tag, d, disp[d], e[d].s);
      end
    end
    read_display(1'b1);
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (disp[d] != e[d].h) begin
        miscompares++;
        $display("FAIL %s dut%0d high got %0d want %0d", tag, d, disp[d], e[d].h);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (sc_of(d) !== 5'b10000 || strobe_of(d) != 0) begin
        miscompares++;
        $display("FAIL reset_display dut%0d got sc %b idx %0d want 10000 idx 0", d, sc_of(d),
                 strobe_of(d));
      end
    end
    push_expect();
    check_sb("reset");
  endtask

  task automatic test_strobe();
    logic [4:0] sc;
    bit         seen;
    do_reset();
    for (int k = 0; k < 24; k++) begin
      for (int d = 0; d < 3; d++) begin
        vectors++;
        if (strobe_of(d) != (k / 4) % nd(d)) begin
          miscompares++;
          $display("FAIL strobe_seq dut%0d cycle %0d got %0d want %0d", d, k, strobe_of(d),
                   (k / 4) % nd(d));
        end
      end
      @(posedge clk); #1;
    end
    seen = 1'b0;
    for (int k = 0; k < 16 && !seen; k++) begin
      if (strobe_of(2) == 2) begin
        seen = 1'b1;
        show = 1'b1; #1;
        sc = sc_of(2);
        vectors++;
        if (sc[4] !== 1'b0) begin
          miscompares++;
          $display("FAIL show_high_dot got %b want 0", sc[4]);
        end
        show = 1'b0; #1;
        sc = sc_of(2);
        vectors++;
        if (sc[4] !== 1'b1) begin
          miscompares++;
          $display("FAIL show_low_dot got %b want 1", sc[4]);
        end
      end else begin
        @(posedge clk); #1;
      end
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL strobe_reach_msd got no index 2 want index 2 within 16 cycles");
    end
  endtask

  task automatic test_count();
    logic [1:0] fl;
    do_reset();
    do_inc(4'd1);
    fl = flags_of(0);
    vectors++;
    if (fl[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL new_high_latency got %b want 1", fl[1]);
    end
    do_inc(4'd1);
    do_inc(4'd1);
    push_expect();
    check_sb("count3");
  endtask

  task automatic test_carry();
    do_reset();
    repeat (10) do_inc(4'd9);
    do_inc(4'd8);
    push_expect();
    check_sb("score98");
    do_inc(4'd5);
    push_expect();
    check_sb("carry103");
  endtask

  task automatic test_clear();
    do_reset();
    repeat (4) do_inc(4'd9);
    do_inc(4'd6);
    do_clear(1'b0);
    push_expect();
    check_sb("clear42");
    repeat (4) do_inc(4'd9);
    do_inc(4'd4);
    push_expect();
    check_sb("round2_40");
    do_inc(4'd3);
    push_expect();
    check_sb("round2_43");
  endtask

  task automatic test_same_edge();
    do_reset();
    do_inc(4'd7);
    do_clear(1'b1);
    push_expect();
    check_sb("clear_wins");
  endtask

  task automatic test_bad_inc();
    do_reset();
    do_inc(4'd0);
    do_inc(4'd12);
    do_inc(4'd15);
    push_expect();
    check_sb("bad_inc");
  endtask

  task automatic test_overflow();
    do_reset();
    repeat (1110) do_inc(4'd9);
    do_inc(4'd7);
    push_expect();
    check_sb("score9997");
    do_inc(4'd9);
    push_expect();
    check_sb("overflow");
    do_clear(1'b0);
    push_expect();
    check_sb("overflow_clear");
  endtask

  task automatic test_reset_override();
    do_reset();
    do_inc(4'd4);
    do_inc(4'd6);
    rst = 1'b1; tr = 1'b1; clr = 1'b1; inc = 4'd3;
    @(posedge clk); #1;
    rst = 1'b0; tr = 1'b0; clr = 1'b0;
    model_reset();
    push_expect();
    check_sb("reset_override");
  endtask

  initial begin
    test_reset();
    test_strobe();
    test_count();
    test_carry();
    test_clear();
    test_same_edge();
    test_bad_inc();
    test_overflow();
    test_reset_override();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
